// File: rtl/fdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fdiv_sequencer
// Purpose  : IEEE-754 single-precision divide sequencer around an external
//            fraction divider; handles specials, normalisation and rounding.
// Option   : FDIV_ROUND_NEAREST_EN -> round-to-nearest-even, else truncate.
// Revision : 1.0 - initial release
// ============================================================================
module fdiv_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic [4:0]  flags,
    output logic        busy,
    output logic        ready,
    output logic [31:0] frac_a,
    output logic [31:0] frac_b,
    output logic        div_start,
    input  logic [31:0] div_q,
    input  logic        div_ready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_NORM  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [31:0] C_QNAN    = 32'h7FC0_0000;
    localparam logic [4:0]  C_FL_NV   = 5'b10000;
    localparam logic [4:0]  C_FL_DZ   = 5'b01000;
    localparam logic [4:0]  C_FL_OF   = 5'b00101;
    localparam logic [4:0]  C_FL_UF   = 5'b00011;

    state_t r_state;
    state_t w_next;

    logic        r_sign;
    logic [7:0]  r_ea;
    logic [7:0]  r_eb;
    logic [31:0] r_q;

    // ------------------------------------------------------------------------
    // Operand classification (exponent 0 is treated as zero)
    // ------------------------------------------------------------------------
    logic w_a_emax, w_b_emax;
    logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic w_special, w_sign, w_accept;

    assign w_a_emax  = &a[30:23];
    assign w_b_emax  = &b[30:23];
    assign w_a_zero  = ~|a[30:23];
    assign w_b_zero  = ~|b[30:23];
    assign w_a_inf   = w_a_emax & ~|a[22:0];
    assign w_b_inf   = w_b_emax & ~|b[22:0];
    assign w_a_nan   = w_a_emax & |a[22:0];
    assign w_b_nan   = w_b_emax & |b[22:0];
    assign w_special = w_a_emax | w_b_emax | w_a_zero | w_b_zero;
    assign w_sign    = a[31] ^ b[31];
    assign w_accept  = (r_state == S_IDLE) && start;

    logic [31:0] w_sp_result;
    logic [4:0]  w_sp_flags;

    always_comb begin
        w_sp_result = {w_sign, 31'd0};
        w_sp_flags  = 5'd0;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_sp_result = C_QNAN;
            w_sp_flags  = C_FL_NV;
        end else if (w_a_inf) begin
            w_sp_result = {w_sign, 8'hFF, 23'd0};
        end else if (w_b_zero) begin
            w_sp_result = {w_sign, 8'hFF, 23'd0};
            w_sp_flags  = C_FL_DZ;
        end
    end

    // ------------------------------------------------------------------------
    // Normalise and round the captured quotient
    // ------------------------------------------------------------------------
    logic [23:0]       w_mant;
    logic              w_guard, w_sticky, w_inc, w_carry, w_inexact;
    logic [22:0]       w_frac_r;
    logic signed [9:0] w_bias, w_exp, w_exp_r;
    logic [31:0]       w_nm_result;
    logic [4:0]        w_nm_flags;

    assign w_mant   = r_q[31] ? r_q[31:8] : r_q[30:7];
    assign w_guard  = r_q[31] ? r_q[7]    : r_q[6];
    assign w_sticky = r_q[31] ? |r_q[6:0] : |r_q[5:0];
    assign w_bias   = r_q[31] ? 10'sd127  : 10'sd126;
    assign w_exp    = $signed({2'b00, r_ea}) - $signed({2'b00, r_eb}) + w_bias;

`ifdef FDIV_ROUND_NEAREST_EN
    assign w_inc = w_guard & (w_sticky | w_mant[0]);
`else
    assign w_inc = 1'b0;
`endif

    // An all-ones mantissa that rounds up wraps the fraction to zero (1.0).
    assign w_carry   = (&w_mant) & w_inc;
    assign w_frac_r  = w_mant[22:0] + {22'd0, w_inc};
    assign w_exp_r   = w_carry ? (w_exp + 10'sd1) : w_exp;
    assign w_inexact = w_guard | w_sticky;

    always_comb begin
        w_nm_result = {r_sign, w_exp_r[7:0], w_frac_r};
        w_nm_flags  = {4'd0, w_inexact};
        if (w_exp_r >= 10'sd255) begin
            w_nm_result = {r_sign, 8'hFF, 23'd0};
            w_nm_flags  = C_FL_OF;
        end else if (w_exp_r <= 10'sd0) begin
            w_nm_result = {r_sign, 31'd0};
            w_nm_flags  = C_FL_UF;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        busy      = 1'b0;
        ready     = 1'b0;
        div_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_special ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy      = 1'b1;
                div_start = 1'b1;
                w_next    = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (div_ready) begin
                    w_next = S_NORM;
                end
            end
            S_NORM: begin
                busy   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                ready  = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sign <= 1'b0;
            r_ea   <= 8'd0;
            r_eb   <= 8'd0;
            r_q    <= 32'd0;
            result <= 32'd0;
            flags  <= 5'd0;
            frac_a <= 32'd0;
            frac_b <= 32'd0;
        end else begin
            if (w_accept) begin
                r_sign <= w_sign;
                r_ea   <= a[30:23];
                r_eb   <= b[30:23];
                if (w_special) begin
                    result <= w_sp_result;
                    flags  <= w_sp_flags;
                end else begin
                    frac_a <= {1'b1, a[22:0], 8'h00};
                    frac_b <= {1'b1, b[22:0], 8'h00};
                end
            end
            if ((r_state == S_WAIT) && div_ready) begin
                r_q <= div_q;
            end
            if (r_state == S_NORM) begin
                result <= w_nm_result;
                flags  <= w_nm_flags;
            end
        end
    end

endmodule
`default_nettype wire
